// File: rtl/instr_imm_encoder.sv
// Two-stage immediate encoder: S1 merges the immediate into the base word, S2 holds the output.
// Define IMM_RANGE_CHECK_EN to flag out-of-range immediates and illegal types on out_err.
module instr_imm_encoder (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  imm_type,
   input  logic [31:0] imm,
   input  logic [31:0] base,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic        out_err,
   output logic [15:0] enc_count
);

   localparam logic [2:0] TYPE_I = 3'b000;
   localparam logic [2:0] TYPE_S = 3'b001;
   localparam logic [2:0] TYPE_B = 3'b010;
   localparam logic [2:0] TYPE_U = 3'b011;
   localparam logic [2:0] TYPE_J = 3'b100;

   logic        s1_valid_q, s2_valid_q;
   logic [31:0] s1_instr_q, s2_instr_q;
   logic [15:0] cnt_q, cnt_d;
   logic [31:0] enc_instr_d;
   logic        s2_move, out_hs;

   // S2 frees up when empty or draining; S1 frees up when empty or moving into S2.
   assign s2_move  = !s2_valid_q || out_ready;
   assign in_ready = !s1_valid_q || s2_move;
   assign out_hs   = s2_valid_q && out_ready;
   assign cnt_d    = cnt_q + 16'd1;

   always_comb begin
      enc_instr_d = base;
      case (imm_type)
         TYPE_I: enc_instr_d[31:20] = imm[11:0];
         TYPE_S: begin
            enc_instr_d[31:25] = imm[11:5];
            enc_instr_d[11:7]  = imm[4:0];
         end
         TYPE_B: begin
            enc_instr_d[31]    = imm[12];
            enc_instr_d[30:25] = imm[10:5];
            enc_instr_d[11:8]  = imm[4:1];
            enc_instr_d[7]     = imm[11];
         end
         TYPE_U: enc_instr_d[31:12] = imm[31:12];
         TYPE_J: begin
            enc_instr_d[31]    = imm[20];
            enc_instr_d[30:21] = imm[10:1];
            enc_instr_d[20]    = imm[11];
            enc_instr_d[19:12] = imm[19:12];
         end
         default: enc_instr_d = base;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s1_instr_q <= '0;
         s2_instr_q <= '0;
         cnt_q      <= '0;
      end else begin
         if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) s1_instr_q <= enc_instr_d;
         end
         if (s2_move) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) s2_instr_q <= s1_instr_q;
         end
         if (out_hs) cnt_q <= cnt_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign out_instr = s2_instr_q;
   assign enc_count = cnt_q;

`ifdef IMM_RANGE_CHECK_EN
   logic range_err_d;
   logic s1_err_q, s2_err_q;

   // Signed range checks reduce to "all bits above the field are copies of its sign bit".
   always_comb begin
      range_err_d = 1'b0;
      case (imm_type)
         TYPE_I, TYPE_S: range_err_d = !((&imm[31:11]) || !(|imm[31:11]));
         TYPE_B: range_err_d = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
         TYPE_U: range_err_d = |imm[11:0];
         TYPE_J: range_err_d = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
         default: range_err_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_err_q <= 1'b0;
         s2_err_q <= 1'b0;
      end else begin
         if (in_ready && in_valid) s1_err_q <= range_err_d;
         if (s2_move && s1_valid_q) s2_err_q <= s1_err_q;
      end
   end

   assign out_err = s2_err_q;
`else
   assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_imm_encoder.sv
// Directed bench for instr_imm_encoder: vector table streamed through the pipe plus
// hand-written latency, backpressure, reset and counter-wrap sequences.
module tb_instr_imm_encoder;

`ifdef IMM_RANGE_CHECK_EN
   localparam logic CHK = 1'b1;
`else
   localparam logic CHK = 1'b0;
`endif

   localparam int NV = 16;

   typedef struct {
      logic [2:0]  t;
      logic [31:0] imm;
      logic [31:0] base;
      logic [31:0] exp;
      logic        err;
   } vec_t;

   vec_t vecs[NV];

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  imm_type;
   logic [31:0] imm;
   logic [31:0] base;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic        out_err;
   logic [15:0] enc_count;

   int checks = 0;
   int errors = 0;

   instr_imm_encoder dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .imm_type  (imm_type),
      .imm       (imm),
      .base      (base),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_err   (out_err),
      .enc_count (enc_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive_vec(input int i);
      in_valid = 1'b1;
      imm_type = vecs[i].t;
      imm      = vecs[i].imm;
      base     = vecs[i].base;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      imm_type  = 3'b000;
      imm       = '0;
      base      = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      int idx_in, idx_out, cyc, acc, n;
      logic seen, hs;
      logic [31:0] held;

      vecs[0]  = '{3'b000, 32'd5,         32'h00000093, 32'h00500093, 1'b0};
      vecs[1]  = '{3'b001, 32'd8,         32'h0020A023, 32'h0020A423, 1'b0};
      vecs[2]  = '{3'b010, 32'hFFFFFFFC,  32'h00000063, 32'hFE000EE3, 1'b0};
      vecs[3]  = '{3'b011, 32'h12345000,  32'h000002B7, 32'h123452B7, 1'b0};
      vecs[4]  = '{3'b100, 32'd8,         32'h0000006F, 32'h0080006F, 1'b0};
      vecs[5]  = '{3'b000, 32'd2048,      32'h00000093, 32'h80000093, 1'b1};
      vecs[6]  = '{3'b101, 32'd2048,      32'h00000093, 32'h00000093, 1'b1};
      vecs[7]  = '{3'b000, 32'hFFFFFFFF,  32'h00000093, 32'hFFF00093, 1'b0};
      vecs[8]  = '{3'b010, 32'd3,         32'h00000063, 32'h00000163, 1'b1};
      vecs[9]  = '{3'b011, 32'h00001001,  32'h00000037, 32'h00001037, 1'b1};
      vecs[10] = '{3'b100, 32'h000FFFFE,  32'h0000006F, 32'h7FFFF06F, 1'b0};
      vecs[11] = '{3'b100, 32'h00100000,  32'h0000006F, 32'h8000006F, 1'b1};
      vecs[12] = '{3'b001, 32'hFFFFF800,  32'h0020A023, 32'h8020A023, 1'b0};
      vecs[13] = '{3'b010, 32'hFFFFF000,  32'h00000063, 32'h80000063, 1'b0};
      vecs[14] = '{3'b010, 32'h00001000,  32'h00000063, 32'h80000063, 1'b1};
      vecs[15] = '{3'b000, 32'd1,         32'hFFF00093, 32'h00100093, 1'b0};

      // reset state
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      imm_type = 3'b000; imm = '0; base = '0;
      #2;
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_out_instr", out_instr, 32'd0);
      check("rst_out_err",   {31'b0, out_err}, 32'd0);
      check("rst_enc_count", {16'b0, enc_count}, 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);

      // two-edge latency
      out_ready = 1'b1;
      drive_vec(0);
      @(posedge clk); #1 in_valid = 1'b0;
      check("lat_edge1_valid", {31'b0, out_valid}, 32'd0);
      @(posedge clk); #1;
      check("lat_edge2_valid", {31'b0, out_valid}, 32'd1);
      check("lat_edge2_instr", out_instr, 32'h00500093);
      @(posedge clk); #1;

      // table stream at full throughput
      do_reset();
      out_ready = 1'b1;
      idx_in = 0; idx_out = 0; cyc = 0;
      drive_vec(0);
      while (idx_out < NV && cyc < NV + 20) begin
         @(negedge clk);
         if (out_valid) begin
            check($sformatf("vec%0d_instr", idx_out), out_instr, vecs[idx_out].exp);
            check($sformatf("vec%0d_err", idx_out), {31'b0, out_err}, {31'b0, vecs[idx_out].err & CHK});
            idx_out++;
         end
         if (in_valid && in_ready) idx_in++;
         if (idx_out == NV) break;
         @(posedge clk); #1; cyc++;
         if (idx_in < NV) drive_vec(idx_in); else in_valid = 1'b0;
      end
      check("stream_cycles", cyc, NV + 1);
      @(posedge clk); #1 in_valid = 1'b0;
      check("stream_count", {16'b0, enc_count}, NV);

      // backpressure: 4 inputs, out_ready low for 5 cycles
      do_reset();
      acc = 0; seen = 1'b0; held = '0;
      drive_vec(0);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         hs = in_valid && in_ready;
         if (out_valid) begin
            if (seen) check("bp_hold_instr", out_instr, held);
            else begin held = out_instr; seen = 1'b1; end
         end
         @(posedge clk);
         if (hs) acc++;
         #1;
         if (acc < 4) drive_vec(acc); else in_valid = 1'b0;
      end
      check("bp_accepted", acc, 2);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      check("bp_head_instr", out_instr, vecs[0].exp);
      out_ready = 1'b1;
      idx_out = 0; cyc = 0;
      while (idx_out < 4 && cyc < 20) begin
         @(negedge clk);
         hs = in_valid && in_ready;
         if (out_valid) begin
            check($sformatf("bp_out%0d", idx_out), out_instr, vecs[idx_out].exp);
            idx_out++;
         end
         @(posedge clk);
         if (hs) acc++;
         #1; cyc++;
         if (acc < 4) drive_vec(acc); else in_valid = 1'b0;
      end
      check("bp_out_total", idx_out, 4);
      check("bp_enc_count", {16'b0, enc_count}, 32'd4);

      // reset with two entries in flight
      do_reset();
      out_ready = 1'b1;
      drive_vec(1);
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 out_ready = 1'b0;
      check("rmid_count_pre", {16'b0, enc_count}, 32'd1);
      drive_vec(2);
      @(posedge clk); #1 drive_vec(3);
      @(posedge clk); #1 in_valid = 1'b0;
      check("rmid_valid_pre", {31'b0, out_valid}, 32'd1);
      #1 rst = 1'b1;
      #1;
      check("rmid_valid", {31'b0, out_valid}, 32'd0);
      check("rmid_count", {16'b0, enc_count}, 32'd0);
      check("rmid_instr", out_instr, 32'd0);
      @(negedge clk) rst = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check("rmid_no_stale", {31'b0, out_valid}, 32'd0);
      end
      check("rmid_in_ready", {31'b0, in_ready}, 32'd1);

      // enc_count wrap after 65536 handshakes
      do_reset();
      out_ready = 1'b1;
      drive_vec(0);
      n = 0; cyc = 0;
      while (n < 65536 && cyc < 70000) begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            if (n == 65535) check("wrap_pre", {16'b0, enc_count}, 32'h0000FFFF);
            n++;
         end
         if (n == 65536) break;
         @(posedge clk); cyc++;
      end
      @(posedge clk); #1 in_valid = 1'b0;
      check("wrap_handshakes", n, 65536);
      check("wrap_count", {16'b0, enc_count}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
